// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame state
// encoding, the sync byte and the load error codes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  // A frame length is usable when it is non-zero and fits the memory.
  function automatic logic lenOk(input logic [15:0] len, input int memBytes);
    return (len != 16'd0) && (int'(len) <= memBytes);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses A5 / LEN_HI / LEN_LO / data / CSUM frames
// and writes the payload into instruction memory starting at address 0.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          load_busy,
  output logic          load_done,
  output logic [1:0]    load_err
);

  // Handshake: a byte moves only on a rising edge where rx_valid && rx_ready;
  // rx_ready is 1 in every cycle out of reset, so the sender is never stalled.

  state_t      state;
  logic [15:0] lenReg;
  logic [15:0] addrCnt;
  logic [7:0]  sum;
  logic        accept;
  logic        isSync;
  logic [15:0] lenFull;

  assign accept  = rx_valid && rx_ready;
  assign isSync  = (rx_data == SYNC_BYTE);
  assign lenFull = {lenReg[15:8], rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lenReg    <= '0;
      addrCnt   <= '0;
      sum       <= '0;
      rx_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      load_err  <= ERR_NONE;
    end else begin
      rx_ready <= 1'b1;
      wr_en    <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (isSync) begin
              state     <= S_LEN_HI;
              load_busy <= 1'b1;
            end
          end
          S_LEN_HI: begin
            lenReg[15:8] <= rx_data;
            state        <= S_LEN_LO;
          end
          S_LEN_LO: begin
            lenReg <= lenFull;
            if (lenOk(lenFull, MEM_BYTES)) begin
              state   <= S_DATA;
              addrCnt <= '0;
              sum     <= '0;
            end else begin
              state     <= S_ERR;
              load_err  <= ERR_LEN;
              load_busy <= 1'b0;
            end
          end
          S_DATA: begin
            // Write lands one cycle after the byte; counter never passes lenReg.
            wr_en   <= 1'b1;
            wr_addr <= addrCnt[AW-1:0];
            wr_data <= rx_data;
            sum     <= sum + rx_data;
            addrCnt <= addrCnt + 16'd1;
            if (addrCnt + 16'd1 == lenReg) begin
              state <= S_CSUM;
            end
          end
          S_CSUM: begin
            load_busy <= 1'b0;
            if (rx_data == sum) begin
              state     <= S_DONE;
              load_done <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= ERR_CSUM;
            end
          end
          S_DONE, S_ERR: begin
            if (isSync) begin
              state     <= S_LEN_HI;
              load_busy <= 1'b1;
              load_done <= 1'b0;
              load_err  <= ERR_NONE;
            end
          end
          default: begin
            state     <= S_IDLE;
            load_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning instruction-memory size in bytes.
REQ-002 SHALL have parameter AW, default 10, meaning write-address width, equal to clog2(MEM_BYTES).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_valid  input  1  incoming byte valid.
REQ-006 SHALL have port rx_data  input  8  incoming byte.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port wr_en  output  1  instruction-memory byte write strobe.
REQ-009 SHALL have port wr_addr  output  AW  instruction-memory byte address.
REQ-010 SHALL have port wr_data  output  8  byte to write.
REQ-011 SHALL have port load_busy  output  1  frame in progress; processor held, F_pred_pc not advanced.
REQ-012 SHALL have port load_done  output  1  image loaded and checksum good; processor may run from PC 0.
REQ-013 SHALL have port load_err  output  2  00 none, 01 bad length, 10 checksum mismatch.

Function
REQ-014 SHALL treat a byte as accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-015 SHALL drive rx_ready=1 in every state except RESET; there is no backpressure.
REQ-016 SHALL accept frames of: sync 0xA5, LEN_HI, LEN_LO, LEN data bytes, CSUM.
REQ-017 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
REQ-018 In IDLE, SHALL go to LEN_HI on accepted 0xA5; other bytes are discarded.
REQ-019 In LEN_HI and LEN_LO, SHALL capture the 16-bit big-endian length.
REQ-020 On LEN_LO accept, SHALL go to ERR with load_err=01 if length is 0 or greater than MEM_BYTES; otherwise it SHALL go to DATA with address counter=0 and sum=0.
REQ-021 In DATA, each accepted byte SHALL produce wr_en=1 on the next cycle, with wr_addr=counter and wr_data=byte (latency 1, registered).
REQ-022 In DATA, each accepted byte SHALL add the byte to sum (8-bit sum, wraps mod 256) and increment the counter.
REQ-023 SHALL go to CSUM after the byte that makes counter==length.
REQ-024 SHALL hold wr_en at 0 in all cycles other than those in REQ-021.
REQ-025 On CSUM accept, SHALL go to DONE if the byte equals sum; otherwise it SHALL go to ERR with load_err=10.
REQ-026 SHALL assert load_busy from the cycle after sync accept until the cycle DONE or ERR is entered.
REQ-027 SHALL keep load_done high only while in DONE.
REQ-028 In DONE or ERR, an accepted 0xA5 SHALL restart at LEN_HI and clear load_done/load_err in the next cycle; other bytes are ignored.
REQ-029 SHALL hold state while rx_valid=0 in any state, with no timeout.
REQ-030 SHALL NOT write beyond address length-1 (MEM_BYTES-1 at most), since the counter cannot exceed length.
REQ-031 SHALL pass 0xA5 inside DATA or at CSUM as data/checksum; it is not treated as a resync.

Reset
REQ-032 While rst_n=0, SHALL hold state at IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, load_busy=0, load_done=0, load_err=00, and length/counter/sum=0.
REQ-033 A reset asserted mid-frame SHALL abort immediately; a pending write SHALL be dropped, already-written bytes are left untouched, and the next load needs a fresh sync.
REQ-034 SHALL drive rx_ready=1 from the first rising clk edge after rst_n deasserts.

Structure
REQ-035 SHALL place the state encoding, SYNC_BYTE=8'hA5 and the load_err codes in a shared package used by loader and bench.
REQ-036 SHALL be a single module with no sub-module; the checksum accumulator is inline.

Verification
REQ-037 Bench SHALL check: A5 00 03 10 20 30 60 -> writes (0,10),(1,20),(2,30) on consecutive cycles, then load_done=1 and load_err=00.
REQ-038 Bench SHALL check: A5 00 02 01 02 04 -> two writes, then load_err=10 and load_done=0.
REQ-039 Bench SHALL check: A5 00 00, and A5 04 01 with MEM_BYTES=1024 -> load_err=01 with no wr_en.
REQ-040 Bench SHALL check: 11 22 A5 00 01 A5 A5 -> leading bytes ignored, write (0,A5), then load_done=1.
REQ-041 Bench SHALL check: rst_n low after 2 of 5 data bytes -> outputs at reset values immediately, and a following full frame loads correctly.
REQ-042 Bench SHALL check: rx_valid gaps of random length between bytes -> same write sequence and result as the gapless case.
